// File: rtl/code_duel_ctrl.sv
// Two-player code-breaking game controller: secret entry, alternating guesses,
// serial exact/partial scoring with duplicate handling, turn limit and result hold.
module code_duel_ctrl #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TURNS   = 8,
    parameter int HOLD_CYCLES = 255,
    localparam int CW     = $clog2(DIGITS + 1),
    localparam int TW     = $clog2(MAX_TURNS + 1),
    localparam int CODE_W = DIGITS * DIGIT_W,
    localparam int HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CODE_W-1:0] switches_i,
    input  logic              btn_pulse_i,
    output logic [2:0]        state_o,
    output logic              active_player_o,
    output logic [TW-1:0]     turn_o,
    output logic [CW-1:0]     exact_o,
    output logic [CW-1:0]     partial_o,
    output logic              result_valid_o,
    output logic              busy_o,
    output logic [1:0]        winner_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_P1_SECRET = 3'd1,
        S_P2_SECRET = 3'd2,
        S_P1_GUESS  = 3'd3,
        S_P2_GUESS  = 3'd4,
        S_SCORE     = 3'd5,
        S_GAME_OVER = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               player_q, player_d;
    logic [TW-1:0]      turn_q, turn_d;
    logic [CW-1:0]      exact_q, exact_d;
    logic [CW-1:0]      partial_q, partial_d;
    logic               rv_q, rv_d;
    logic [1:0]         winner_q, winner_d;
    logic [CODE_W-1:0]  secret_a_q, secret_a_d;
    logic [CODE_W-1:0]  secret_b_q, secret_b_d;
    logic [CODE_W-1:0]  guess_q, guess_d;
    logic [CODE_W-1:0]  target_q, target_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [CW-1:0]      k_q, k_d;
    logic [DIGITS-1:0]  consumed_q, consumed_d;
    logic [CW-1:0]      ex_acc_q, ex_acc_d;
    logic [CW-1:0]      pa_acc_q, pa_acc_d;

    logic [DIGITS-1:0]  eq_mask;
    logic [DIGIT_W-1:0] g_k;
    logic               hit_exact;
    logic               found;
    logic [DIGITS-1:0]  cons_set;
    logic [TW-1:0]      turn_inc;

    // Exact positions come from the full vectors, so a partial search can never steal them.
    always_comb begin
        eq_mask   = '0;
        g_k       = '0;
        hit_exact = 1'b0;
        found     = 1'b0;
        cons_set  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            eq_mask[i] = (guess_q[i*DIGIT_W +: DIGIT_W] == target_q[i*DIGIT_W +: DIGIT_W]);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (k_q == CW'(i)) begin
                g_k       = guess_q[i*DIGIT_W +: DIGIT_W];
                hit_exact = eq_mask[i];
            end
        end
        for (int j = 0; j < DIGITS; j++) begin
            if (!found && !eq_mask[j] && !consumed_q[j] &&
                (target_q[j*DIGIT_W +: DIGIT_W] == g_k)) begin
                found       = 1'b1;
                cons_set[j] = 1'b1;
            end
        end
    end

    assign turn_inc = (player_q && (turn_q != TW'(MAX_TURNS))) ? turn_q + TW'(1) : turn_q;

    always_comb begin
        state_d    = state_q;
        player_d   = player_q;
        turn_d     = turn_q;
        exact_d    = exact_q;
        partial_d  = partial_q;
        rv_d       = 1'b0;
        winner_d   = winner_q;
        secret_a_d = secret_a_q;
        secret_b_d = secret_b_q;
        guess_d    = guess_q;
        target_d   = target_q;
        hold_d     = hold_q;
        k_d        = k_q;
        consumed_d = consumed_q;
        ex_acc_d   = ex_acc_q;
        pa_acc_d   = pa_acc_q;

        case (state_q)
            S_IDLE: begin
                if (btn_pulse_i) begin
                    state_d   = S_P1_SECRET;
                    player_d  = 1'b0;
                    turn_d    = '0;
                    exact_d   = '0;
                    partial_d = '0;
                    winner_d  = 2'd0;
                end
            end
            S_P1_SECRET: begin
                if (btn_pulse_i) begin
                    secret_a_d = switches_i;
                    player_d   = 1'b1;
                    state_d    = S_P2_SECRET;
                end
            end
            S_P2_SECRET: begin
                if (btn_pulse_i) begin
                    secret_b_d = switches_i;
                    player_d   = 1'b0;
                    state_d    = S_P1_GUESS;
                end
            end
            S_P1_GUESS, S_P2_GUESS: begin
                if (btn_pulse_i) begin
                    guess_d    = switches_i;
                    target_d   = (state_q == S_P1_GUESS) ? secret_b_q : secret_a_q;
                    k_d        = '0;
                    consumed_d = '0;
                    ex_acc_d   = '0;
                    pa_acc_d   = '0;
                    state_d    = S_SCORE;
                end
            end
            S_SCORE: begin
                if (k_q != CW'(DIGITS)) begin
                    k_d = k_q + CW'(1);
                    if (hit_exact) begin
                        ex_acc_d = ex_acc_q + CW'(1);
                    end else if (found) begin
                        pa_acc_d   = pa_acc_q + CW'(1);
                        consumed_d = consumed_q | cons_set;
                    end
                end else begin
                    // Commit cycle: publish the totals and pick the next phase.
                    exact_d   = ex_acc_q;
                    partial_d = pa_acc_q;
                    rv_d      = 1'b1;
                    hold_d    = '0;
                    if (ex_acc_q == CW'(DIGITS)) begin
                        winner_d = player_q ? 2'd2 : 2'd1;
                        state_d  = S_GAME_OVER;
                    end else begin
                        turn_d = turn_inc;
                        if (player_q && (turn_inc == TW'(MAX_TURNS))) begin
                            winner_d = 2'd3;
                            state_d  = S_GAME_OVER;
                        end else begin
                            player_d = ~player_q;
                            state_d  = player_q ? S_P1_GUESS : S_P2_GUESS;
                        end
                    end
                end
            end
            S_GAME_OVER: begin
                if (btn_pulse_i || (hold_q == HW'(HOLD_CYCLES - 1))) begin
                    hold_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            player_q   <= 1'b0;
            turn_q     <= '0;
            exact_q    <= '0;
            partial_q  <= '0;
            rv_q       <= 1'b0;
            winner_q   <= 2'd0;
            secret_a_q <= '0;
            secret_b_q <= '0;
            guess_q    <= '0;
            target_q   <= '0;
            hold_q     <= '0;
            k_q        <= '0;
            consumed_q <= '0;
            ex_acc_q   <= '0;
            pa_acc_q   <= '0;
        end else begin
            state_q    <= state_d;
            player_q   <= player_d;
            turn_q     <= turn_d;
            exact_q    <= exact_d;
            partial_q  <= partial_d;
            rv_q       <= rv_d;
            winner_q   <= winner_d;
            secret_a_q <= secret_a_d;
            secret_b_q <= secret_b_d;
            guess_q    <= guess_d;
            target_q   <= target_d;
            hold_q     <= hold_d;
            k_q        <= k_d;
            consumed_q <= consumed_d;
            ex_acc_q   <= ex_acc_d;
            pa_acc_q   <= pa_acc_d;
        end
    end

    assign state_o         = state_q;
    assign active_player_o = player_q;
    assign turn_o          = turn_q;
    assign exact_o         = exact_q;
    assign partial_o       = partial_q;
    assign result_valid_o  = rv_q;
    // The commit cycle is not counted as scoring work.
    assign busy_o          = (state_q == S_SCORE) && (k_q != CW'(DIGITS));
    assign winner_o        = winner_q;

endmodule

// File: doc/code_duel_ctrl.md
# code_duel_ctrl

Parametrised two-player code-breaking game controller: each player enters a secret code, then the players alternate guesses against the opponent's secret. Each guess is scored as exact hits (right digit, right position) and partial hits (right digit, wrong position), with correct duplicate handling. The block enforces a turn limit, declares a win or draw, and holds the result for a configurable time. It sits between the debounced button / switch inputs and the seven-segment display formatter; it drives no display segments itself.

## Interface
- DIGITS, 4, number of code digits (≥2)
- DIGIT_W, 4, bits per digit
- MAX_TURNS, 8, rounds before a draw (1 round = P1 guess + P2 guess)
- HOLD_CYCLES, 255, cycles GAME_OVER is held before returning to IDLE (≥1)
- Derived: CW = $clog2(DIGITS+1), TW = $clog2(MAX_TURNS+1)

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high; all state cleared immediately
- switches  in  DIGITS*DIGIT_W  code entry; digit i = switches[i*DIGIT_W +: DIGIT_W]
- btn_pulse  in  1  single-cycle, already debounced/edge-detected press
- state  out  3  current FSM state encoding
- active_player  out  1  0 = P1, 1 = P2; player whose entry or guess is expected
- turn  out  TW  completed rounds
- exact  out  CW  exact hits of the last scored guess
- partial  out  CW  partial hits of the last scored guess
- result_valid  out  1  one-cycle pulse when exact/partial are updated
- busy  out  1  high while scoring
- winner  out  2  0 = none, 1 = P1, 2 = P2, 3 = draw

## Operation
- States (encoding): IDLE=0, P1_SECRET=1, P2_SECRET=2, P1_GUESS=3, P2_GUESS=4, SCORE=5, GAME_OVER=6.
- IDLE: btn_pulse → P1_SECRET; clears turn, exact, partial and winner.
- P1_SECRET: btn_pulse latches switches into secret_a → P2_SECRET.
- P2_SECRET: btn_pulse latches switches into secret_b → P1_GUESS.
- P1_GUESS: btn_pulse latches the guess and sets target = secret_b → SCORE.
- P2_GUESS: btn_pulse latches the guess and sets target = secret_a → SCORE.
- SCORE: busy=1; runs for exactly DIGITS cycles, processing guess digit k = 0..DIGITS-1, one per cycle:
  - If g[k]==s[k], count exact.
  - Otherwise search the lowest j where s[j]≠g[j], j not yet consumed, and s[j]==g[k]; if found, mark j consumed and count partial.
  - Exact positions are never consumed by partial matches; positions are pre-classified from full vectors in the first cycle.
  - Result equals the standard rule: partial = Σ_v min(cnt_s(v), cnt_g(v)) − exact.
- After the last digit:
  - Write exact/partial and pulse result_valid.
  - exact==DIGITS → GAME_OVER, winner = active_player+1.
  - Else, if the scorer was P2, turn++; if the new turn==MAX_TURNS → GAME_OVER with winner=3.
  - Else toggle active_player and go to the other player's GUESS state.
- GAME_OVER: hold counter counts up. At HOLD_CYCLES−1, or on btn_pulse, → IDLE. winner persists until IDLE is left.
- btn_pulse is ignored in SCORE. Switch changes are ignored except on the latching edge.
- Counters saturate: turn never exceeds MAX_TURNS, and there is no wrap.

## Timing
- Reset values: state=IDLE, active_player=0, turn=0, exact=0, partial=0, result_valid=0, busy=0, winner=0. Secrets, guess and hold counter are cleared.
- Latching edge: the clk edge sampling btn_pulse=1; the state changes on that same edge.
- busy is high from the cycle after the guess latch for DIGITS cycles.
- result_valid and the updated exact/partial appear on the edge ending SCORE, i.e. DIGITS+1 edges after the latching edge. The next state is entered on that same edge.
- exact/partial hold until the next result_valid or IDLE exit.
- GAME_OVER lasts HOLD_CYCLES cycles when undisturbed.
- rst asserted mid-SCORE or mid-hold: outputs reach reset values without waiting for clk. There is no residual result_valid after release.

## Test plan
- Reset → IDLE; press ×3 entering secret_a=0x1234, secret_b=0x5678; verify states 1→2→3. P1 guesses 0x5687 → after 5 cycles exact=2, partial=2, result_valid for 1 cycle, state=P2_GUESS.
- Duplicates: secret_b=0x1122, guess 0x2211 → exact=0, partial=4. Secret_b=0x1123, guess 0x1111 → exact=2, partial=0.
- Win: P2 guesses 0x1234 against secret_a=0x1234 → exact=4, winner=2, GAME_OVER held 255 cycles, then IDLE. Repeat with btn_pulse during hold → IDLE next edge.
- Draw: MAX_TURNS=2, four non-matching guesses → turn=2, winner=3 after P2's second score.
- btn_pulse during SCORE is ignored (no extra latch, latency unchanged). Async rst asserted mid-SCORE → all outputs reset without a clk edge; a new game after release scores correctly.
